// File: rtl/rtmc_pkg.sv
// Shared types and constants for the register-bus arbiter and its helpers.
`timescale 1ns/1ps
package rtmc_pkg;

    localparam int REG_ADDR_W = 8;
    localparam int REG_DATA_W = 16;

    // Read data returned to an initiator whose access was terminated by timeout.
    localparam logic [15:0] RTMC_BUS_ERR_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_DONE
    } arb_state_t;

endpackage

// File: rtl/rtmc_rr_pick.sv
// Combinational round-robin selector: first requester found scanning from ptr+1 upward (wrapping).
`timescale 1ns/1ps
module rtmc_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
        int s;
        s = (int'(p) + 1 + k) % N;
        return IW'(s);
    endfunction

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[wrap_idx(ptr, k)]) begin
                valid = 1'b1;
                idx   = wrap_idx(ptr, k);
            end
        end
        if (valid) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rtmc_reg_arb.sv
// Round-robin arbiter sharing one register responder between N_INI initiators,
// with registered strobes and a per-access timeout that returns an error word.
`timescale 1ns/1ps
module rtmc_reg_arb
    import rtmc_pkg::*;
#(
    parameter int N_INI  = 2,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    parameter int TO_CYC = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_INI*ADDR_W-1:0] ini_addr,
    input  logic [N_INI*DATA_W-1:0] ini_wdat,
    input  logic [N_INI-1:0]        ini_wr,
    input  logic [N_INI-1:0]        ini_rd,
    output logic [N_INI*DATA_W-1:0] ini_rdat,
    output logic [N_INI-1:0]        ini_ack,
    output logic [ADDR_W-1:0]       rsp_addr,
    output logic [DATA_W-1:0]       rsp_wdat,
    output logic                    rsp_wr,
    output logic                    rsp_rd,
    input  logic [DATA_W-1:0]       rsp_rdat,
    input  logic                    rsp_ack,
    output logic [N_INI-1:0]        grant,
    output logic                    err_to,
    input  logic                    err_clr
);

    localparam int IW = (N_INI > 1) ? $clog2(N_INI) : 1;
    localparam int CW = $clog2(TO_CYC + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);
    localparam logic [IW-1:0] PTR_RST = IW'(N_INI - 1);

    arb_state_t          state_reg, state_next;
    logic [IW-1:0]       ptr_reg, ptr_next;
    logic [IW-1:0]       win_reg, win_next;
    logic [N_INI-1:0]    grant_reg, grant_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdat_reg, wdat_next;
    logic                wr_reg, wr_next;
    logic                rd_reg, rd_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic                err_reg, err_next;
    logic                err_set;

    logic [N_INI-1:0]    req;
    logic [N_INI-1:0]    pick_onehot;
    logic [IW-1:0]       pick_idx;
    logic                pick_valid;
    logic [ADDR_W-1:0]   pick_addr;
    logic [DATA_W-1:0]   pick_wdat;
    logic                pick_wr;

    generate
        for (genvar gi = 0; gi < N_INI; gi++) begin : g_req
            assign req[gi] = ini_wr[gi] | ini_rd[gi];
        end
    endgenerate

    rtmc_rr_pick #(
        .N  (N_INI),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_addr = '0;
        pick_wdat = '0;
        pick_wr   = 1'b0;
        for (int i = 0; i < N_INI; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_addr = ini_addr[i*ADDR_W +: ADDR_W];
                pick_wdat = ini_wdat[i*DATA_W +: DATA_W];
                pick_wr   = ini_wr[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        win_next   = win_reg;
        grant_next = grant_reg;
        addr_next  = addr_reg;
        wdat_next  = wdat_reg;
        wr_next    = wr_reg;
        rd_next    = rd_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        err_set    = 1'b0;
        case (state_reg)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_next = ARB_ISSUE;
                    ptr_next   = pick_idx;
                    win_next   = pick_idx;
                    grant_next = pick_onehot;
                    addr_next  = pick_addr;
                    wdat_next  = pick_wdat;
                    // A simultaneous wr and rd is treated as a write.
                    wr_next    = pick_wr;
                    rd_next    = ~pick_wr;
                    cnt_next   = '0;
                end
            end
            ARB_ISSUE: begin
                cnt_next = cnt_reg + CW'(1);
                if (rsp_ack) begin
                    data_next  = rsp_rdat;
                    state_next = ARB_DONE;
                end else if (cnt_reg == TO_LAST) begin
                    data_next  = DATA_W'(RTMC_BUS_ERR_DATA);
                    err_set    = 1'b1;
                    state_next = ARB_DONE;
                end
                if (state_next == ARB_DONE) begin
                    wr_next    = 1'b0;
                    rd_next    = 1'b0;
                    grant_next = '0;
                end
            end
            ARB_DONE: begin
                // Requests are deliberately not sampled here so a dropping initiator is not re-granted.
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
        err_next = err_set ? 1'b1 : (err_clr ? 1'b0 : err_reg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ARB_IDLE;
            ptr_reg   <= PTR_RST;
            win_reg   <= '0;
            grant_reg <= '0;
            addr_reg  <= '0;
            wdat_reg  <= '0;
            wr_reg    <= 1'b0;
            rd_reg    <= 1'b0;
            cnt_reg   <= '0;
            data_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            win_reg   <= win_next;
            grant_reg <= grant_next;
            addr_reg  <= addr_next;
            wdat_reg  <= wdat_next;
            wr_reg    <= wr_next;
            rd_reg    <= rd_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            err_reg   <= err_next;
        end
    end

    generate
        for (genvar gi = 0; gi < N_INI; gi++) begin : g_ret
            assign ini_ack[gi] = (state_reg == ARB_DONE) && (win_reg == IW'(gi));
            assign ini_rdat[gi*DATA_W +: DATA_W] = ini_ack[gi] ? data_reg : '0;
        end
    endgenerate

    assign rsp_addr = addr_reg;
    assign rsp_wdat = wdat_reg;
    assign rsp_wr   = wr_reg;
    assign rsp_rd   = rd_reg;
    assign grant    = grant_reg;
    assign err_to   = err_reg;

endmodule
